// File: rtl/pwl_activation_pipe.sv
// Programmable piecewise-linear activation: y = bias[k] +/- ((x - start[k]) >> shift[k]).
// Three pipeline stages: segment select, slope shift, bias add with saturation.
module pwl_activation_pipe #(
   parameter int DATA_W  = 16,
   parameter int SEGS    = 8,
   parameter int SHIFT_W = 5,
   localparam int AW     = $clog2(SEGS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [DATA_W-1:0]  cfg_start,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic               cfg_neg,
   input  logic [DATA_W-1:0]  cfg_bias,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_x,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_y
);

   localparam int SW = DATA_W + 2;

   logic [DATA_W-1:0]  t_start [SEGS];
   logic [SHIFT_W-1:0] t_shift [SEGS];
   logic               t_neg   [SEGS];
   logic [DATA_W-1:0]  t_bias  [SEGS];

   logic en1, en2, en3;
   logic v1, v2, v3;

   logic [DATA_W-1:0]  x1, s1, b1;
   logic [SHIFT_W-1:0] sh1;
   logic               ng1, z1;

   logic [DATA_W:0]    t2;
   logic [DATA_W-1:0]  b2;
   logic               ng2;

   logic [AW-1:0]      k;
   logic               below;
   logic [DATA_W:0]    delta;
   logic [DATA_W:0]    term;
   logic [SW-1:0]      sum;
   logic [DATA_W-1:0]  sat;

   assign en3       = !v3 || out_ready;
   assign en2       = !v2 || en3;
   assign en1       = !v1 || en2;
   assign in_ready  = en1;
   assign out_valid = v3;

   // Reset table maps every input to a constant zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < SEGS; i++) begin
            t_start[i] <= {1'b1, {(DATA_W-1){1'b0}}};
            t_shift[i] <= '1;
            t_neg[i]   <= 1'b0;
            t_bias[i]  <= '0;
         end
      end else if (cfg_we) begin
         t_start[cfg_addr] <= cfg_start;
         t_shift[cfg_addr] <= cfg_shift;
         t_neg[cfg_addr]   <= cfg_neg;
         t_bias[cfg_addr]  <= cfg_bias;
      end
   end

   always_comb begin
      k = '0;
      for (int i = 0; i < SEGS; i++) begin
         if ($signed(in_x) >= $signed(t_start[i])) k = AW'(i);
      end
      below = $signed(in_x) < $signed(t_start[0]);
      if (below) k = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v1 <= 1'b0;
      end else if (en1) begin
         v1  <= in_valid;
         x1  <= in_x;
         s1  <= t_start[k];
         sh1 <= t_shift[k];
         ng1 <= t_neg[k];
         b1  <= t_bias[k];
         z1  <= below;
      end
   end

   always_comb begin
      delta = {x1[DATA_W-1], x1} - {s1[DATA_W-1], s1};
      if (z1) delta = '0;
      term = (sh1 == '1) ? '0 : (delta >> sh1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v2 <= 1'b0;
      end else if (en2) begin
         v2  <= v1;
         t2  <= term;
         b2  <= b1;
         ng2 <= ng1;
      end
   end

   // Sum is in range when the bits above the output sign all agree.
   always_comb begin
      if (ng2) sum = {{2{b2[DATA_W-1]}}, b2} - {1'b0, t2};
      else     sum = {{2{b2[DATA_W-1]}}, b2} + {1'b0, t2};
      if (sum[SW-1:DATA_W-1] == '0 || sum[SW-1:DATA_W-1] == '1)
         sat = sum[DATA_W-1:0];
      else if (sum[SW-1])
         sat = {1'b1, {(DATA_W-1){1'b0}}};
      else
         sat = {1'b0, {(DATA_W-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v3    <= 1'b0;
         out_y <= '0;
      end else if (en3) begin
         v3 <= v2;
         if (v2) out_y <= sat;
      end
   end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// Bench for pwl_activation_pipe: vector tables, stall stream,
// config-vs-sample ordering and mid-stream reset, via a scoreboard.
module tb_pwl_activation_pipe;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_start;
   logic [4:0]  cfg_shift;
   logic        cfg_neg;
   logic [15:0] cfg_bias;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_y;

   pwl_activation_pipe dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_start(cfg_start),
      .cfg_shift(cfg_shift), .cfg_neg(cfg_neg), .cfg_bias(cfg_bias),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          n_out  = 0;
   logic [15:0] exp_q [$];
   logic [15:0] exp_next;
   logic [15:0] e;
   logic        acc;
   logic        ir_seen;
   vec_t        vq [$];

   logic signed [15:0] m_start [8];
   logic [4:0]         m_shift [8];
   logic               m_neg   [8];
   logic signed [15:0] m_bias  [8];

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", nm, act, exp);
      end
   endtask

   // One clock: scoreboard at negedge, inputs change 1 after posedge.
   task automatic tick();
      @(negedge clk);
      acc     = 1'b0;
      ir_seen = in_ready;
      if (!rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected got=%h expected none", out_y);
            end else begin
               e = exp_q.pop_front();
               chk("sb_out_y", out_y, e);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(exp_next);
            acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model(input logic signed [15:0] x);
      int     k;
      longint d, s;
      k = 0;
      for (int i = 0; i < 8; i++) if (x >= m_start[i]) k = i;
      if (x < m_start[0]) begin
         k = 0;
         d = 0;
      end else begin
         d = longint'(x) - longint'(m_start[k]);
      end
      if (m_shift[k] == 5'h1f) d = 0;
      else d = d >>> m_shift[k];
      s = m_neg[k] ? longint'(m_bias[k]) - d : longint'(m_bias[k]) + d;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   task automatic mirror_reset();
      for (int i = 0; i < 8; i++) begin
         m_start[i] = 16'sh8000;
         m_shift[i] = 5'h1f;
         m_neg[i]   = 1'b0;
         m_bias[i]  = 16'sh0000;
      end
   endtask

   task automatic cfg(input int a, input logic [15:0] st,
                      input logic [4:0] sh, input logic ng,
                      input logic [15:0] b);
      cfg_we    = 1'b1;
      cfg_addr  = 3'(a);
      cfg_start = st;
      cfg_shift = sh;
      cfg_neg   = ng;
      cfg_bias  = b;
      tick();
      m_start[a] = st;
      m_shift[a] = sh;
      m_neg[a]   = ng;
      m_bias[a]  = b;
      cfg_we = 1'b0;
   endtask

   // Entry 1 active from 0 upward; entries 2..7 only at 0x7FFF.
   task automatic fence_table();
      cfg(1, 16'h0000, 5'd2, 1'b0, 16'h0080);
      for (int a = 2; a < 8; a++) cfg(a, 16'h7FFF, 5'h1f, 1'b0, 16'h0000);
   endtask

   task automatic flat_table(input logic ng, input logic [15:0] b);
      for (int a = 1; a < 8; a++) cfg(a, 16'h0000, 5'd0, ng, b);
   endtask

   task automatic send(input logic [15:0] x, input logic [15:0] y);
      in_valid = 1'b1;
      in_x     = x;
      exp_next = y;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (acc) return;
      end
      checks++;
      errors++;
      $display("FAIL send_timeout got=in_ready_low expected=accept");
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0 && !out_valid) return;
         tick();
      end
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d pending expected=0", exp_q.size());
   endtask

   task automatic run_vecs();
      out_ready = 1'b1;
      foreach (vq[i]) send(vq[i].x, vq[i].y);
      drain();
      vq.delete();
   endtask

   function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y);
      vec_t v;
      v.x = x;
      v.y = y;
      return v;
   endfunction

   logic [15:0] xs [10];
   int          sent;
   int          base;

   initial begin
      rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_start = '0;
      cfg_shift = '0; cfg_neg = 1'b0; cfg_bias = '0;
      in_valid = 1'b0; in_x = '0; out_ready = 1'b1; exp_next = '0;
      mirror_reset();
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("rst_out_valid", 16'(out_valid), 16'h0);
      chk("rst_out_y", out_y, 16'h0000);
      chk("rst_in_ready", 16'(in_ready), 16'h1);

      // Latency: presented in cycle 0, visible in cycle 3.
      in_valid = 1'b1; in_x = 16'h1234; exp_next = 16'h0000;
      tick();
      chk("t1_accept", 16'(acc), 16'h1);
      in_valid = 1'b0;
      chk("t1_c1_valid", 16'(out_valid), 16'h0);
      tick();
      chk("t1_c2_valid", 16'(out_valid), 16'h0);
      tick();
      chk("t1_c3_valid", 16'(out_valid), 16'h1);
      chk("t1_c3_y", out_y, 16'h0000);
      drain();

      fence_table();
      vq.push_back(mk(16'h0040, 16'h0090));
      vq.push_back(mk(16'hFFFB, 16'h0000));
      vq.push_back(mk(16'h0000, 16'h0080));
      vq.push_back(mk(16'h0003, 16'h0080));
      vq.push_back(mk(16'h0004, 16'h0081));
      vq.push_back(mk(16'h7FFE, 16'h207F));
      vq.push_back(mk(16'h7FFF, 16'h0000));
      vq.push_back(mk(16'h8000, 16'h0000));
      run_vecs();

      flat_table(1'b0, 16'h7F00);
      vq.push_back(mk(16'h7FFF, 16'h7FFF));
      vq.push_back(mk(16'h0000, 16'h7F00));
      vq.push_back(mk(16'h00FF, 16'h7FFF));
      vq.push_back(mk(16'h0100, 16'h7FFF));
      vq.push_back(mk(16'hFFFF, 16'h0000));
      run_vecs();

      flat_table(1'b1, 16'h8100);
      vq.push_back(mk(16'h7FFF, 16'h8000));
      vq.push_back(mk(16'h00FF, 16'h8001));
      vq.push_back(mk(16'h0100, 16'h8000));
      vq.push_back(mk(16'h0000, 16'h8100));
      run_vecs();

      // Stall stream: downstream blocked in cycles 2..6.
      fence_table();
      for (int i = 0; i < 10; i++) xs[i] = 16'(i * 16'h0D35 - 16'h1800);
      sent = 0;
      base = n_out;
      for (int c = 0; c < 200; c++) begin
         if (sent >= 10 && exp_q.size() == 0 && !out_valid) break;
         in_valid  = (sent < 10);
         in_x      = xs[sent < 10 ? sent : 9];
         exp_next  = model(in_x);
         out_ready = !(c >= 2 && c <= 6);
         tick();
         if (acc) sent++;
         if (c == 6) chk("t4_in_ready_full", 16'(ir_seen), 16'h0);
      end
      drain();
      chk("t4_out_count", 16'(n_out - base), 16'd10);
      chk("t4_sent", 16'(sent), 16'd10);

      // Config write on the same edge as a sample uses the old entry.
      out_ready = 1'b1;
      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_start = 16'h0000;
      cfg_shift = 5'd2; cfg_neg = 1'b0; cfg_bias = 16'h0100;
      in_valid = 1'b1; in_x = 16'h0040; exp_next = 16'h0090;
      tick();
      chk("t5_same_edge_accept", 16'(acc), 16'h1);
      m_bias[1] = 16'sh0100;
      cfg_we = 1'b0;
      in_x = 16'h0040; exp_next = 16'h0110;
      tick();
      chk("t5_next_accept", 16'(acc), 16'h1);
      drain();

      // Reset with three samples in flight.
      for (int i = 0; i < 3; i++) send(16'h0040 + 16'(i), 16'h0110);
      in_valid = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      mirror_reset();
      chk("t6_out_valid", 16'(out_valid), 16'h0);
      tick();
      chk("t6_out_valid_2", 16'(out_valid), 16'h0);
      send(16'h0040, 16'h0000);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
